// File: rtl/user_gpio_pkg.sv
// Shared definitions for the user GPIO Wishbone controller: register word offsets,
// ID register fields and the per-channel edge selection type.
package user_gpio_pkg;

    localparam logic [5:0] OFF_OUT      = 6'h00;
    localparam logic [5:0] OFF_OEB      = 6'h01;
    localparam logic [5:0] OFF_IN       = 6'h02;
    localparam logic [5:0] OFF_IRQ_EN   = 6'h03;
    localparam logic [5:0] OFF_IRQ_STAT = 6'h04;
    localparam logic [5:0] OFF_EDGE_CFG = 6'h05;
    localparam logic [5:0] OFF_ID       = 6'h06;

    localparam logic [15:0] ID_REV   = 16'h0001;
    localparam logic [7:0]  ID_MAGIC = 8'hA5;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_cfg_e;

endpackage

// File: rtl/gpio_in_chan.sv
// One GPIO input channel: 2-flop synchroniser, optional debouncer and edge detector.
// Build option: GPIO_DEBOUNCE_EN adds a DEB_CYCLES stability counter before edge detection.
module gpio_in_chan
    import user_gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = 4
)
`endif
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_pad,
    input  edge_cfg_e i_edge,
    output logic      o_level,
    output logic      o_event
);

    logic r_meta;
    logic r_sync;
    logic r_hist;
    logic w_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic       r_deb;
    logic [7:0] r_cnt;

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == 8'(DEB_CYCLES - 1)) begin
            r_deb <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= w_level;
        end
    end

    // Edges come only from level history, so changing i_edge alone never fires.
    always_comb begin
        o_event = 1'b0;
        if (i_edge == EDGE_RISE) begin
            o_event = w_level & ~r_hist;
        end else begin
            o_event = ~w_level & r_hist;
        end
    end

    assign o_level = w_level;

endmodule

// File: rtl/user_gpio_wb_ctrl.sv
// Wishbone-slave GPIO controller owning the user io_out/io_oeb bundle, with edge interrupts.
// Build option: GPIO_DEBOUNCE_EN enables per-channel input debouncing of DEB_CYCLES cycles.
module user_gpio_wb_ctrl
    import user_gpio_pkg::*;
#(
    parameter int          N_IO       = 27,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DEB_CYCLES = 4
)
(
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [N_IO-1:0] io_in,
    output logic [N_IO-1:0] io_out,
    output logic [N_IO-1:0] io_oeb,
    output logic            irq_o
);

    if (N_IO < 1 || N_IO > 32 || DEB_CYCLES < 2 || DEB_CYCLES > 255 ||
        BASE_ADDR[7:0] != 8'h00) begin : g_bad_cfg
        $error("user_gpio_wb_ctrl: parameter out of range");
    end

    logic [N_IO-1:0] r_out;
    logic [N_IO-1:0] r_oeb;
    logic [N_IO-1:0] r_irq_en;
    logic [N_IO-1:0] r_irq_stat;
    logic [N_IO-1:0] r_edge_cfg;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_irq;

    logic            w_req;
    logic            w_take;
    logic            w_wr;
    logic [5:0]      w_off;
    logic [31:0]     w_bmask;
    logic [31:0]     w_rdata;
    logic [N_IO-1:0] w_wmask;
    logic [N_IO-1:0] w_wbits;
    logic [N_IO-1:0] w_clr;
    logic [N_IO-1:0] w_level;
    logic [N_IO-1:0] w_event;
    logic            w_unused_ok;

    function automatic logic [N_IO-1:0] merge(input logic [N_IO-1:0] old_v,
                                              input logic [N_IO-1:0] new_v,
                                              input logic [N_IO-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_take  = w_req & ~r_ack;
    assign w_wr    = w_take & wbs_we_i;
    assign w_off   = wbs_adr_i[7:2];
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_wmask = w_bmask[N_IO-1:0];
    assign w_wbits = wbs_dat_i[N_IO-1:0];
    assign w_clr   = (w_wr && w_off == OFF_IRQ_STAT) ? (w_wbits & w_wmask) : '0;
    assign w_unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i};

    for (genvar i = 0; i < N_IO; i++) begin : g_chan
`ifdef GPIO_DEBOUNCE_EN
        gpio_in_chan #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_chan (
            .i_clk   (wb_clk_i),
            .i_rst   (wb_rst_i),
            .i_pad   (io_in[i]),
            .i_edge  (edge_cfg_e'(r_edge_cfg[i])),
            .o_level (w_level[i]),
            .o_event (w_event[i])
        );
`else
        gpio_in_chan u_chan (
            .i_clk   (wb_clk_i),
            .i_rst   (wb_rst_i),
            .i_pad   (io_in[i]),
            .i_edge  (edge_cfg_e'(r_edge_cfg[i])),
            .o_level (w_level[i]),
            .o_event (w_event[i])
        );
`endif
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_OUT:      w_rdata = 32'(r_out);
            OFF_OEB:      w_rdata = 32'(r_oeb);
            OFF_IN:       w_rdata = 32'(w_level);
            OFF_IRQ_EN:   w_rdata = 32'(r_irq_en);
            OFF_IRQ_STAT: w_rdata = 32'(r_irq_stat);
            OFF_EDGE_CFG: w_rdata = 32'(r_edge_cfg);
            OFF_ID:       w_rdata = {ID_MAGIC, 8'(N_IO), ID_REV};
            default:      w_rdata = '0;
        endcase
    end

    // Ack is a single-cycle pulse; a held request must see ack low before it is taken again.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_take;
            r_dat <= (w_take && !wbs_we_i) ? w_rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out      <= '0;
            r_oeb      <= '1;
            r_irq_en   <= '0;
            r_edge_cfg <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_OUT:      r_out      <= merge(r_out, w_wbits, w_wmask);
                OFF_OEB:      r_oeb      <= merge(r_oeb, w_wbits, w_wmask);
                OFF_IRQ_EN:   r_irq_en   <= merge(r_irq_en, w_wbits, w_wmask);
                OFF_EDGE_CFG: r_edge_cfg <= merge(r_edge_cfg, w_wbits, w_wmask);
                default:      r_out      <= r_out;
            endcase
        end
    end

    // A new event overrides a same-cycle write-1-to-clear of that bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_event;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_out;
    assign io_oeb    = r_oeb;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_user_gpio_wb_ctrl.sv
// Self-checking bench for user_gpio_wb_ctrl: register table, interrupt corner sequences
// and randomized register traffic against a simple register-map model.
module tb_user_gpio_wb_ctrl;

    localparam int          N_IO    = 27;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] CH_MASK = 32'h07FF_FFFF;
    localparam logic [31:0] ID_VAL  = 32'hA51B_0001;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int IN_LAT = 2 + DEB;

    logic            wbClk;
    logic            wbRst;
    logic            stb;
    logic            cyc;
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     datIn;
    logic [31:0]     adr;
    logic            ack;
    logic [31:0]     datOut;
    logic [N_IO-1:0] ioIn;
    logic [N_IO-1:0] ioOut;
    logic [N_IO-1:0] ioOeb;
    logic            irq;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] expRd;
        logic [31:0] expOut;
        logic [31:0] expOeb;
    } vec_t;

    vec_t vecs[$];

    user_gpio_wb_ctrl #(
        .N_IO       (N_IO),
        .BASE_ADDR  (BASE),
        .DEB_CYCLES (4)
    ) dut (
        .wb_clk_i  (wbClk),
        .wb_rst_i  (wbRst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (datIn),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (datOut),
        .io_in     (ioIn),
        .io_out    (ioOut),
        .io_oeb    (ioOeb),
        .irq_o     (irq)
    );

    initial begin
        wbClk = 1'b0;
        forever #5 wbClk = ~wbClk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge wbClk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts a request now and waits (bounded) for ack; lat is 99 when no ack came.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output logic [31:0] rd, output int lat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; datIn = d; sel = s;
        rd  = '0;
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ack) begin
                rd  = datOut;
                lat = c;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic busOp(input string name, input logic w, input logic [7:0] off,
                         input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        int lat;
        applyStimulus(w, BASE + 32'(off), d, s, rd, lat);
        checkOutput({name, " ack latency"}, 32'(lat), 32'd1);
        tick();
        checkOutput({name, " ack width"}, 32'(ack), 32'd0);
    endtask

    function automatic vec_t mkVec(string n, logic w, logic [7:0] o, logic [31:0] d, logic [3:0] s,
                                   logic [31:0] r, logic [31:0] eo, logic [31:0] eb);
        vec_t v;
        v.name = n; v.we = w; v.off = o; v.dat = d; v.sel = s;
        v.expRd = r; v.expOut = eo; v.expOeb = eb;
        return v;
    endfunction

    function automatic logic [31:0] applyWrite(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        end
        return res & CH_MASK;
    endfunction

    initial begin
        logic [31:0] rd;
        int          lat;
        int          first;
        int          acks;
        logic [31:0] mOut, mOeb, mEn, mCfg;
        int          offs[8];

        wbRst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; datIn = 0; adr = 0; ioIn = '0;
        repeat (2) @(posedge wbClk);
        #1;
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset dat", datOut, 32'd0);
        checkOutput("reset irq", 32'(irq), 32'd0);
        checkOutput("reset io_out", 32'(ioOut), 32'd0);
        checkOutput("reset io_oeb", 32'(ioOeb), CH_MASK);
        #2 wbRst = 1'b0;
        tick();

        vecs.push_back(mkVec("rdOEB",   0, 8'h04, 0,            4'hF, CH_MASK,      0,            CH_MASK));
        vecs.push_back(mkVec("rdOUT",   0, 8'h00, 0,            4'hF, 0,            0,            CH_MASK));
        vecs.push_back(mkVec("rdID",    0, 8'h18, 0,            4'hF, ID_VAL,       0,            CH_MASK));
        vecs.push_back(mkVec("rdSTAT",  0, 8'h10, 0,            4'hF, 0,            0,            CH_MASK));
        vecs.push_back(mkVec("wrOUTb0", 1, 8'h00, 32'h0000_00A5, 4'h1, 0,           32'h0000_00A5, CH_MASK));
        vecs.push_back(mkVec("wrOUTb1", 1, 8'h00, 32'hFFFF_FFFF, 4'h2, 0,           32'h0000_FFA5, CH_MASK));
        vecs.push_back(mkVec("rdOUT2",  0, 8'h00, 0,            4'hF, 32'h0000_FFA5, 32'h0000_FFA5, CH_MASK));
        vecs.push_back(mkVec("wrOEB",   1, 8'h04, 32'hFFFF_0000, 4'h3, 0,           32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdOEBlo", 0, 8'h07, 0,            4'hF, 32'h07FF_0000, 32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrEN",    1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 0,           32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdEN",    0, 8'h0C, 0,            4'hF, CH_MASK,      32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdGap",   0, 8'h3C, 0,            4'hF, 0,            32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrGap",   1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 0,           32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdIN",    0, 8'h08, 0,            4'hF, 0,            32'h0000_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrOUTb3", 1, 8'h00, 32'hFFFF_FFFF, 4'h8, 0,           32'h0700_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrEN8",   1, 8'h0C, 32'h0000_0008, 4'hF, 0,           32'h0700_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrCFG",   1, 8'h14, 32'h0000_0020, 4'hF, 0,           32'h0700_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdCFG",   0, 8'h14, 0,            4'hF, 32'h0000_0020, 32'h0700_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("wrID",    1, 8'h18, 32'h0000_0000, 4'hF, 0,           32'h0700_FFA5, 32'h07FF_0000));
        vecs.push_back(mkVec("rdID2",   0, 8'h18, 0,            4'hF, ID_VAL,       32'h0700_FFA5, 32'h07FF_0000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, rd, lat);
            checkOutput({vecs[i].name, " ack latency"}, 32'(lat), 32'd1);
            if (!vecs[i].we) checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].expRd);
            checkOutput({vecs[i].name, " io_out"}, 32'(ioOut), vecs[i].expOut);
            checkOutput({vecs[i].name, " io_oeb"}, 32'(ioOeb), vecs[i].expOeb);
            tick();
            checkOutput({vecs[i].name, " ack width"}, 32'(ack), 32'd0);
        end

        // Rising edge on channel 3 with its interrupt enabled.
        ioIn[3] = 1'b1;
        first = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (irq && first == 0) first = c;
        end
        checkOutput("irq latency", 32'(first), 32'(4 + DEB));
        busOp("rdIN3", 0, 8'h08, 0, 4'hF, rd);
        checkOutput("IN bit3", rd, 32'h0000_0008);
        busOp("rdSTAT3", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT bit3", rd, 32'h0000_0008);
        busOp("w1c3", 1, 8'h10, 32'h0000_0008, 4'hF, rd);
        checkOutput("irq after w1c", 32'(irq), 32'd0);
        busOp("rdSTAT3b", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT cleared", rd, 32'd0);

        // Channel 5 is falling-edge: a rise must not set status, a fall racing a W1C must.
        ioIn[5] = 1'b1;
        repeat (IN_LAT + 3) tick();
        busOp("rdSTAT5r", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT no rise on fall-cfg", rd, 32'd0);
        ioIn[5] = 1'b0;
        repeat (IN_LAT) tick();
        busOp("w1c5race", 1, 8'h10, 32'h0000_0020, 4'h1, rd);
        busOp("rdSTAT5", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT set wins", rd, 32'h0000_0020);
        checkOutput("irq masked bit5", 32'(irq), 32'd0);
        busOp("w1c5", 1, 8'h10, 32'h0000_0020, 4'h1, rd);
        busOp("rdSTAT5c", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT5 cleared", rd, 32'd0);

        // Flipping EDGE_CFG on a stable high channel must not create an event.
        ioIn[7] = 1'b1;
        repeat (IN_LAT + 3) tick();
        busOp("w1c7", 1, 8'h10, 32'hFFFF_FFFF, 4'hF, rd);
        busOp("cfg7f", 1, 8'h14, 32'h0000_00A0, 4'hF, rd);
        busOp("cfg7r", 1, 8'h14, 32'h0000_0020, 4'hF, rd);
        repeat (3) tick();
        busOp("rdSTAT7", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT no cfg event", rd, 32'd0);

        // Outside the window and cyc-less strobes get no ack.
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h100;
        acks = 0;
        repeat (4) begin tick(); if (ack) acks++; end
        checkOutput("out-of-window acks", 32'(acks), 32'd0);
        cyc = 0; adr = BASE;
        acks = 0;
        repeat (4) begin tick(); if (ack) acks++; end
        checkOutput("no-cyc acks", 32'(acks), 32'd0);
        cyc = 1; adr = BASE + 32'h18;
        acks = 0;
        repeat (4) begin tick(); if (ack) acks++; end
        checkOutput("held request acks", 32'(acks), 32'd2);
        stb = 0; cyc = 0;
        tick();

`ifdef GPIO_DEBOUNCE_EN
        ioIn[0] = 1'b1;
        repeat (3) tick();
        ioIn[0] = 1'b0;
        repeat (10) tick();
        busOp("rdINglitch", 0, 8'h08, 0, 4'hF, rd);
        checkOutput("IN glitch ignored", rd & 32'h1, 32'd0);
        busOp("rdSTATglitch", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT glitch ignored", rd, 32'd0);
        ioIn[0] = 1'b1;
        repeat (6) tick();
        busOp("rdINpulse", 0, 8'h08, 0, 4'hF, rd);
        checkOutput("IN pulse accepted", rd & 32'h1, 32'd1);
        ioIn[0] = 1'b0;
        repeat (10) tick();
        busOp("rdSTATpulse", 0, 8'h10, 0, 4'hF, rd);
        checkOutput("STAT pulse", rd, 32'd1);
`endif

        // Reset during an acked read, then reset under a pending write.
        ioIn = '0;
        repeat (IN_LAT + 3) tick();
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h18; sel = 4'hF;
        tick();
        checkOutput("pre-reset dat", datOut, ID_VAL);
        #2 wbRst = 1'b1;
        #1;
        checkOutput("reset drops ack", 32'(ack), 32'd0);
        checkOutput("reset drops dat", datOut, 32'd0);
        #2 wbRst = 1'b0;
        stb = 0; cyc = 0;
        tick();
        stb = 1; cyc = 1; we = 1; adr = BASE; datIn = 32'h0000_0055;
        #2 wbRst = 1'b1;
        @(posedge wbClk);
        #1;
        stb = 0; cyc = 0; we = 0;
        checkOutput("reset io_out", 32'(ioOut), 32'd0);
        checkOutput("reset io_oeb", 32'(ioOeb), CH_MASK);
        #2 wbRst = 1'b0;
        tick();
        busOp("rdOUTlost", 0, 8'h00, 0, 4'hF, rd);
        checkOutput("pending write lost", rd, 32'd0);

        // Randomized register traffic against the register-map model.
        mOut = 0; mOeb = CH_MASK; mEn = 0; mCfg = 0;
        offs = '{0, 4, 8, 12, 16, 20, 24, 28};
        for (int n = 0; n < 80; n++) begin
            int          off;
            logic        w;
            logic [31:0] d;
            logic [3:0]  s;
            logic [31:0] exp;
            off = offs[$urandom_range(0, 7)];
            if (off == 28) off = 4 * $urandom_range(7, 63);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            applyStimulus(w, BASE + 32'(off) + 32'($urandom_range(0, 3)), d, s, rd, lat);
            checkOutput("rand ack latency", 32'(lat), 32'd1);
            if (w) begin
                if (off == 0)  mOut = applyWrite(mOut, d, s);
                if (off == 4)  mOeb = applyWrite(mOeb, d, s);
                if (off == 12) mEn  = applyWrite(mEn, d, s);
                if (off == 20) mCfg = applyWrite(mCfg, d, s);
            end else begin
                exp = 0;
                if (off == 0)  exp = mOut;
                if (off == 4)  exp = mOeb;
                if (off == 12) exp = mEn;
                if (off == 20) exp = mCfg;
                if (off == 24) exp = ID_VAL;
                checkOutput($sformatf("rand read 0x%02h", off), rd, exp);
            end
            checkOutput("rand io_out", 32'(ioOut), mOut);
            checkOutput("rand io_oeb", 32'(ioOeb), mOeb);
            tick();
        end
        checkOutput("rand irq", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/user_gpio_wb_ctrl.md
Name: user_gpio_wb_ctrl

Overview:
- Parametrised Wishbone-slave GPIO controller for the user project area.
- Drives the user io_out/io_oeb bundle from memory-mapped registers.
- Synchronises io_in and raises a level interrupt on per-channel configurable edges.
- Next generation of the bare pin wrapper: the pin bundle gains a register-controlled, interrupt-capable owner, sized by parameter.

Parameters:
- N_IO, 27, number of GPIO channels (1..32).
- BASE_ADDR, 32'h3000_0000, register window base; bits [7:0] must be zero.
- DEB_CYCLES, 4, consecutive stable cycles required by the debouncer (GPIO_DEBOUNCE_EN only; range 2..255).

Ports:
- wb_clk_i  input  1  single clock.
- wb_rst_i  input  1  asynchronous active-high reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  N_IO  pad inputs, asynchronous to wb_clk_i.
- io_out  output  N_IO  pad output values.
- io_oeb  output  N_IO  pad output enables, active low.
- irq_o  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high; every flop clears on assertion.
- Reset values:
  - io_out = 0; io_oeb = all ones (all channels inputs).
  - wbs_ack_o = 0; wbs_dat_o = 0; irq_o = 0.
  - OUT, IRQ_EN, IRQ_STAT, EDGE_CFG = 0.
  - Synchroniser and edge history = 0.
- Select: a request is stb & cyc & (adr[31:8] == BASE_ADDR[31:8]). Requests outside the window are ignored; no ack is given.
- Ack timing:
  - ack rises the cycle after a request is seen while ack=0, and stays high exactly 1 cycle.
  - A request held through the ack cycle is not re-acked; the next ack needs ack=0 first, so the minimum transaction is 2 cycles.
- Register map (offset = adr[7:2], word-aligned; adr[1:0] ignored):
  - 0x00 OUT rw.
  - 0x04 OEB rw, reset all ones.
  - 0x08 IN ro, synchronised (and debounced, if enabled) input.
  - 0x0C IRQ_EN rw.
  - 0x10 IRQ_STAT, write-1-to-clear.
  - 0x14 EDGE_CFG rw, per bit: 0 = rising, 1 = falling.
  - 0x18 ID ro, {8'hA5, 8'(N_IO), 16'h0001}.
- Field rules:
  - Only bits [N_IO-1:0] of each register exist; upper bits read 0 and are write-ignored.
  - wbs_sel_i[k] gates byte k on every write.
  - Unmapped offsets inside the window: ack, read 0, writes ignored.
- Write timing: the register updates on the same edge ack rises, so io_out/io_oeb change with ack.
- Read timing: wbs_dat_o is registered with ack and is 0 whenever ack=0.
- Input path: 2-flop synchroniser per channel; IN reflects a pad change 2 cycles later.
- Edge detect: compares the synchronised value with a 1-cycle history; the IRQ_STAT bit sets the cycle after the selected edge.
- Interrupt: irq_o = |(IRQ_STAT & IRQ_EN), registered (1 cycle after status).
- Boundary conditions:
  - A W1C to a bit whose edge arrives in the same cycle leaves the bit set (set wins).
  - Writing EDGE_CFG does not generate a spurious event.
  - IRQ_STAT bits set regardless of IRQ_EN.
  - Reset mid-transaction: ack and dat drop immediately; the pending write is lost.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined: each synchronised channel feeds a counter. The debounced value updates only after DEB_CYCLES consecutive cycles at a new level; any bounce restarts the count. IN latency becomes 2 + DEB_CYCLES cycles, and edges are taken from the debounced value.
- Undefined: no counters; the path is as described above.

Decomposition:
- Package user_gpio_pkg:
  - register offset constants (OFF_OUT .. OFF_ID);
  - ID constant 16'h0001 / 8'hA5;
  - edge-config enum (EDGE_RISE = 0, EDGE_FALL = 1).
- Sub-module gpio_in_chan, instantiated N_IO times:
  - 1-bit synchroniser, optional debouncer, edge detector;
  - outputs: level, event.

Test Plan:
- Reset, then read OEB/OUT/ID -> 0x07FF_FFFF / 0x0 / 0xA51B_0001 for N_IO=27; irq_o=0.
- Write OUT=0x0000_00A5 with sel=4'b0001, then write OUT=0xFFFF_FFFF with sel=4'b0010 -> io_out=0x0000_FFA5; ack high exactly 1 cycle each; io_out changes on the ack edge.
- Drive io_in[3] 0->1 with IRQ_EN=0x8, EDGE_CFG=0 -> IN bit3 set after 2 cycles, IRQ_STAT=0x8 after 3 cycles, irq_o after 4; W1C 0x8 -> irq_o drops.
- Same-cycle W1C of bit5 and falling edge on bit5 (EDGE_CFG[5]=1) -> IRQ_STAT[5] remains 1.
- Access adr = BASE+0x100 -> no ack; access BASE+0x3C -> ack, read 0.
- With GPIO_DEBOUNCE_EN, DEB_CYCLES=4: 3-cycle glitch on io_in[0] -> no IN change and no status; 6-cycle pulse -> IN bit0 at cycle 6 and status set.
